pedestrian_request: RTL and testbench

- Upstream stage of the traffic-light counter. Conditions the raw pedestrian push-button and issues one clean, held crossing request to the counter.
- Internal path: 2-flop synchroniser, then debounce filter, then rising-edge pulse, then request FSM.
- Request handshake with the counter: req/ack, plus a busy level while the crossing phase runs.
- A post-service lockout window rejects repeat presses.

---
 rtl/semafor_pkg.sv | 19 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/pedestrian_request.sv | 90 +++++++++
 tb/tb_pedestrian_request.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semafor_pkg.sv
// Shared types and timing defaults for the traffic-light controller.
// Pedestrian request FSM states and cycle budgets derived from CLK_HZ.
package semafor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2,
        LOCKOUT = 2'd3
    } ped_state_e;

    localparam int CLK_HZ = 50_000_000;

    // 1 ms debounce, 5 ms post-service lockout at CLK_HZ
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 1000;
    localparam int DEF_LOCKOUT_CYCLES  = CLK_HZ / 200;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, debounce filter and
// a registered one-cycle pulse on each debounced rising edge.
module btn_debounce
    import semafor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic btn_clean,
    output logic press_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    logic            s1_q, s2_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            clean_q, clean_d;
    logic            pulse_q, pulse_d;

    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        pulse_d = 1'b0;
        if (s2_q != clean_q) begin
            // the edge that would reach DEBOUNCE_CYCLES flips the level
            if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                clean_d = s2_q;
                pulse_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= button_raw;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
        end
    end

    assign btn_clean   = clean_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/pedestrian_request.sv
// Pedestrian crossing request: conditioned button feeds a req/ack FSM
// with a post-service lockout and a saturating ignored-press counter.
module pedestrian_request
    import semafor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button_raw,
    input  logic             ack,
    input  logic             busy,
    output logic             btn_clean,
    output logic             press_pulse,
    output logic             req,
    output logic             lockout,
    output logic [CNT_W-1:0] ignored_cnt
);

    localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    ped_state_e       state_q, state_d;
    logic [LK_W-1:0]  lk_q, lk_d;
    logic [CNT_W-1:0] ign_q, ign_d;
    logic             req_q, req_d;
    logic             lockout_q, lockout_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .button_raw (button_raw),
        .btn_clean  (btn_clean),
        .press_pulse(press_pulse)
    );

    always_comb begin
        state_d = state_q;
        lk_d    = lk_q;
        ign_d   = ign_q;
        unique case (state_q)
            IDLE: begin
                if (press_pulse) state_d = PENDING;
            end
            PENDING: begin
                if (ack) state_d = SERVING;
            end
            SERVING: begin
                if (!busy) begin
                    state_d = LOCKOUT;
                    lk_d    = LK_W'(LOCKOUT_CYCLES - 1);
                end
            end
            LOCKOUT: begin
                if (lk_q == '0) state_d = IDLE;
                else            lk_d    = lk_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // any press outside IDLE is rejected, counter saturates
        if (press_pulse && state_q != IDLE && ign_q != '1)
            ign_d = ign_q + 1'b1;
        req_d     = (state_d == PENDING);
        lockout_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lk_q      <= '0;
            ign_q     <= '0;
            req_q     <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lk_q      <= lk_d;
            ign_q     <= ign_d;
            req_q     <= req_d;
            lockout_q <= lockout_d;
        end
    end

    assign req         = req_q;
    assign lockout     = lockout_q;
    assign ignored_cnt = ign_q;

endmodule

// File: tb/tb_pedestrian_request.sv
// Self-checking bench for pedestrian_request; expected pulse and req-rise
// cycles are queued when presses are driven and checked by a monitor.
module tb_pedestrian_request;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button_raw = 1'b0, ack = 1'b0, busy = 1'b0;
    logic       btn_clean, press_pulse, req, lockout;
    logic [7:0] ignored_cnt;

    logic       button_raw2 = 1'b0, ack2 = 1'b0, busy2 = 1'b0;
    logic       btn_clean2, press_pulse2, req2, lockout2;
    logic [7:0] ignored_cnt2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_pulse[$];
    int exp_req[$];
    logic req_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pedestrian_request #(
        .DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(10), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .button_raw(button_raw), .ack(ack),
        .busy(busy), .btn_clean(btn_clean), .press_pulse(press_pulse),
        .req(req), .lockout(lockout), .ignored_cnt(ignored_cnt)
    );

    pedestrian_request #(
        .DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(5000), .CNT_W(8)
    ) dut_sat (
        .clk(clk), .rst(rst), .button_raw(button_raw2), .ack(ack2),
        .busy(busy2), .btn_clean(btn_clean2), .press_pulse(press_pulse2),
        .req(req2), .lockout(lockout2), .ignored_cnt(ignored_cnt2)
    );

    // scoreboard monitor on the main instance
    always @(negedge clk) begin
        int e;
        if (press_pulse === 1'b1) begin
            checks++;
            if (exp_pulse.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected cyc=%0d got pulse, want none", cyc);
            end else begin
                e = exp_pulse.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL pulse_cycle got=%0d want=%0d", cyc, e);
                end
            end
        end
        if (req === 1'b1 && req_prev === 1'b0) begin
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected cyc=%0d got rise, want none", cyc);
            end else begin
                e = exp_req.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL req_rise_cycle got=%0d want=%0d", cyc, e);
                end
            end
        end
        req_prev <= req;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit accept);
        exp_pulse.push_back(cyc + 6);
        if (accept) exp_req.push_back(cyc + 7);
        button_raw = 1'b1;
        tick(6);
        button_raw = 1'b0;
        tick(6);
    endtask

    task automatic press2();
        button_raw2 = 1'b1;
        tick(6);
        button_raw2 = 1'b0;
        tick(6);
    endtask

    task automatic pulse_ack(input logic busy_val);
        ack  = 1'b1;
        busy = busy_val;
        tick(1);
        ack  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if ({btn_clean, press_pulse, req, lockout, ignored_cnt} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {btn_clean, press_pulse, req, lockout, ignored_cnt});
        end
        checks++;
        if ({req2, lockout2, ignored_cnt2} !== 10'h0) begin
            errors++;
            $display("FAIL reset_outputs_sat got=%h want=0",
                     {req2, lockout2, ignored_cnt2});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if ({btn_clean, req, lockout, ignored_cnt} !== 11'h0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d got=%h want=0", cyc,
                         {btn_clean, req, lockout, ignored_cnt});
            end
        end
    endtask

    task automatic test_glitch();
        button_raw = 1'b1; tick(1); button_raw = 1'b0; tick(8);
        button_raw = 1'b1; tick(3); button_raw = 1'b0; tick(8);
        checks++;
        if ({btn_clean, req, ignored_cnt} !== 10'h0) begin
            errors++;
            $display("FAIL glitch got=%h want=0", {btn_clean, req, ignored_cnt});
        end
    endtask

    task automatic test_clean_press();
        exp_pulse.push_back(cyc + 6);
        exp_req.push_back(cyc + 7);
        button_raw = 1'b1;
        tick(5);
        checks++;
        if (btn_clean !== 1'b0) begin
            errors++;
            $display("FAIL clean_early got=%b want=0", btn_clean);
        end
        tick(1);
        checks++;
        if (btn_clean !== 1'b1) begin
            errors++;
            $display("FAIL clean_rise got=%b want=1", btn_clean);
        end
        tick(1);
        checks++;
        if ({req, press_pulse} !== 2'b10) begin
            errors++;
            $display("FAIL req_after_pulse got=%b want=10", {req, press_pulse});
        end
        tick(9);
        button_raw = 1'b0;
        tick(8);
        checks++;
        if ({btn_clean, req} !== 2'b01) begin
            errors++;
            $display("FAIL release got=%b want=01", {btn_clean, req});
        end
    endtask

    task automatic test_handshake();
        int n;
        pulse_ack(1'b1);
        checks++;
        if ({req, lockout} !== 2'b00) begin
            errors++;
            $display("FAIL ack_drop got=%b want=00", {req, lockout});
        end
        tick(19);
        checks++;
        if (lockout !== 1'b0) begin
            errors++;
            $display("FAIL serving_lockout got=%b want=0", lockout);
        end
        busy = 1'b0;
        tick(1);
        n = 0;
        while (lockout === 1'b1 && n < 50) begin
            n++;
            tick(1);
        end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL lockout_len got=%0d want=10", n);
        end
    endtask

    task automatic test_ignored();
        press(1'b1);
        press(1'b0);
        checks++;
        if ({req, ignored_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ign_pending got=%b/%0d want=1/1", req, ignored_cnt);
        end
        pulse_ack(1'b1);
        press(1'b0);
        checks++;
        if ({req, ignored_cnt} !== {1'b0, 8'd2}) begin
            errors++;
            $display("FAIL ign_serving got=%b/%0d want=0/2", req, ignored_cnt);
        end
        busy = 1'b0;
        press(1'b0);
        checks++;
        if ({req, lockout, ignored_cnt} !== {2'b00, 8'd3}) begin
            errors++;
            $display("FAIL ign_lockout got=%b%b/%0d want=00/3",
                     req, lockout, ignored_cnt);
        end
        press(1'b1);
        checks++;
        if ({req, ignored_cnt} !== {1'b1, 8'd3}) begin
            errors++;
            $display("FAIL after_lockout got=%b/%0d want=1/3", req, ignored_cnt);
        end
    endtask

    task automatic test_saturate();
        int n;
        press2();
        ack2 = 1'b1; tick(1); ack2 = 1'b0;
        tick(2);
        checks++;
        if ({req2, lockout2} !== 2'b01) begin
            errors++;
            $display("FAIL sat_enter got=%b want=01", {req2, lockout2});
        end
        for (int i = 0; i < 200; i++) press2();
        checks++;
        if (ignored_cnt2 !== 8'd200) begin
            errors++;
            $display("FAIL sat_mid got=%0d want=200", ignored_cnt2);
        end
        for (int i = 0; i < 100; i++) press2();
        checks++;
        if ({lockout2, ignored_cnt2} !== {1'b1, 8'd255}) begin
            errors++;
            $display("FAIL sat_top got=%b/%0d want=1/255", lockout2, ignored_cnt2);
        end
        n = 0;
        while (lockout2 === 1'b1 && n < 6000) begin
            n++;
            tick(1);
        end
        checks++;
        if ({lockout2, req2, ignored_cnt2} !== {2'b00, 8'd255}) begin
            errors++;
            $display("FAIL sat_exit got=%b%b/%0d want=00/255",
                     lockout2, req2, ignored_cnt2);
        end
    endtask

    task automatic test_mid_reset();
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_req got=%b want=1", req);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if ({req, lockout, ignored_cnt} !== 10'h0) begin
            errors++;
            $display("FAIL mid_reset got=%b%b/%0d want=00/0",
                     req, lockout, ignored_cnt);
        end
        tick(2);
        press(1'b1);
        checks++;
        if ({req, ignored_cnt} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL post_reset_press got=%b/%0d want=1/0", req, ignored_cnt);
        end
        pulse_ack(1'b0);
        tick(12);
        checks++;
        if ({req, lockout} !== 2'b00) begin
            errors++;
            $display("FAIL final_idle got=%b want=00", {req, lockout});
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_handshake();
        test_ignored();
        test_saturate();
        test_mid_reset();
        tick(2);
        checks++;
        if (exp_pulse.size() != 0 || exp_req.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d pending want=0/0",
                     exp_pulse.size(), exp_req.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
